// File: rtl/lcc_reply_parser.sv
// lcc_reply_parser
//
// Parses the reply to a request sent over a UART link. After a request
// (iRQ/iRQnum) the block waits for a sync byte 8'h7E, then expects the echoed
// request number, BYTES payload bytes and an 8-bit additive checksum that
// covers the number byte and the payload. A good frame updates oData/oNum and
// pulses oValid; a bad frame, a stalled link or a new request issued while a
// reply is still pending pulses oErr with a cause code.
//
// Build option:
//   LCC_REPLY_CSUM_EN  when defined, the checksum byte is compared against the
//                      running sum. When undefined, the checksum byte is only
//                      consumed and always treated as matching.
//
// Parameters:
//   BYTES     payload bytes per reply frame (1..4)
//   TIMEOUT   maximum clk cycles allowed between bytes
//
// Ports:
//   clk       single clock, rising edge
//   reset     synchronous active-high reset
//   iRQ       one-cycle pulse: a request was sent
//   iRQnum    number of that request, sampled with iRQ
//   iData     received UART byte
//   iValid    iData valid this cycle (one-cycle pulse per byte)
//   oData     last good payload, right-aligned, first byte most significant
//   oNum      request number of the last good reply
//   oValid    one-cycle pulse when oData/oNum update
//   oErr      one-cycle pulse on a failed frame
//   oErrCode  cause of the last error: 01 timeout/abort, 10 number, 11 checksum
//   oErrCnt   saturating error count
//   oBusy     high whenever the parser is not idle
module lcc_reply_parser #(
   parameter int unsigned BYTES   = 4,
   parameter logic [15:0] TIMEOUT = 16'd8064
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        iRQ,
   input  logic [7:0]  iRQnum,
   input  logic [7:0]  iData,
   input  logic        iValid,
   output logic [31:0] oData,
   output logic [7:0]  oNum,
   output logic        oValid,
   output logic        oErr,
   output logic [1:0]  oErrCode,
   output logic [7:0]  oErrCnt,
   output logic        oBusy
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] WAIT_SYNC = 3'd1;
   localparam logic [2:0] NUM       = 3'd2;
   localparam logic [2:0] DATA      = 3'd3;
   localparam logic [2:0] CSUM      = 3'd4;

   localparam logic [1:0] ERR_TMO  = 2'b01;
   localparam logic [1:0] ERR_NUM  = 2'b10;
   localparam logic [1:0] ERR_CSUM = 2'b11;

   localparam logic [7:0]  SYNC_BYTE = 8'h7E;
   localparam logic [15:0] TMO_LAST  = TIMEOUT - 16'd1;
   localparam logic [1:0]  LAST_IDX  = 2'(BYTES - 1);

   logic [2:0]  state;
   logic [15:0] timer;
   logic [1:0]  idx;
   logic [7:0]  rq_num;
   logic [31:0] hold;
   logic        busy;
   logic        tmo_hit;
   logic        csum_ok;
   logic        err_now;
   logic [1:0]  err_code_now;

`ifdef LCC_REPLY_CSUM_EN
   logic [7:0]  sum;
   assign csum_ok = (iData == sum);
`else
   assign csum_ok = 1'b1;
`endif

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign busy    = (state != IDLE);
   assign oBusy   = busy;
   assign tmo_hit = busy && (timer == TMO_LAST);

   // Error decode. Priority mirrors the FSM below: a new request overrides a
   // timeout, and both override whatever byte arrives in the same cycle.
   always_comb begin
      err_now      = 1'b0;
      err_code_now = ERR_TMO;
      if (iRQ) begin
         err_now = busy;
      end else if (tmo_hit) begin
         err_now = 1'b1;
      end else if (iValid && state == NUM && iData != rq_num) begin
         err_now      = 1'b1;
         err_code_now = ERR_NUM;
      end else if (iValid && state == CSUM && !csum_ok) begin
         err_now      = 1'b1;
         err_code_now = ERR_CSUM;
      end
   end

   // Error reporting: pulse, cause and saturating count
   always_ff @(posedge clk) begin
      if (reset) begin
         oErr     <= 1'b0;
         oErrCode <= 2'b00;
         oErrCnt  <= 8'd0;
      end else begin
         oErr <= err_now;
         if (err_now) begin
            oErrCode <= err_code_now;
            oErrCnt  <= sat_inc(oErrCnt);
         end
      end
   end

   // Frame FSM, inter-byte timer and payload capture
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         timer  <= 16'd0;
         idx    <= 2'd0;
         rq_num <= 8'd0;
         hold   <= 32'd0;
`ifdef LCC_REPLY_CSUM_EN
         sum    <= 8'd0;
`endif
         oData  <= 32'd0;
         oNum   <= 8'd0;
         oValid <= 1'b0;
      end else begin
         oValid <= 1'b0;
         if (busy) begin
            timer <= timer + 16'd1;
         end
         if (iRQ) begin
            // Start (or restart) a reply; any frame in progress is dropped.
            rq_num <= iRQnum;
            timer  <= 16'd0;
            state  <= WAIT_SYNC;
         end else if (tmo_hit) begin
            timer <= 16'd0;
            state <= IDLE;
         end else if (iValid) begin
            case (state)
               WAIT_SYNC: begin
                  if (iData == SYNC_BYTE) begin
                     state <= NUM;
                  end
               end
               NUM: begin
                  timer <= 16'd0;
                  if (iData == rq_num) begin
`ifdef LCC_REPLY_CSUM_EN
                     sum   <= iData;
`endif
                     idx   <= 2'd0;
                     hold  <= 32'd0;
                     state <= DATA;
                  end else begin
                     timer <= 16'd0;
                     state <= IDLE;
                  end
               end
               DATA: begin
                  timer <= 16'd0;
                  // Shifting left keeps the payload right-aligned with the
                  // first byte most significant for any BYTES.
                  hold  <= {hold[23:0], iData};
`ifdef LCC_REPLY_CSUM_EN
                  sum   <= sum + iData;
`endif
                  if (idx == LAST_IDX) begin
                     state <= CSUM;
                  end else begin
                     idx <= idx + 2'd1;
                  end
               end
               CSUM: begin
                  timer <= 16'd0;
                  state <= IDLE;
                  if (csum_ok) begin
                     oData  <= hold;
                     oNum   <= rq_num;
                     oValid <= 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lcc_reply_parser.sv
// Testbench for lcc_reply_parser. Directed frames are driven by one process;
// each expected oValid/oErr event is queued with the cycle it must appear in,
// and a monitor on the falling edge pops and compares every event the DUT
// presents. The bench uses a short TIMEOUT so timeout scenarios stay brief.
module tb_lcc_reply_parser;

   localparam int unsigned BYTES   = 4;
   localparam logic [15:0] TIMEOUT = 16'd40;
   localparam int          T       = 40;

   logic        clk;
   logic        reset;
   logic        iRQ;
   logic [7:0]  iRQnum;
   logic [7:0]  iData;
   logic        iValid;
   logic [31:0] oData;
   logic [7:0]  oNum;
   logic        oValid;
   logic        oErr;
   logic [1:0]  oErrCode;
   logic [7:0]  oErrCnt;
   logic        oBusy;

   lcc_reply_parser #(
      .BYTES   (BYTES),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .iRQ      (iRQ),
      .iRQnum   (iRQnum),
      .iData    (iData),
      .iValid   (iValid),
      .oData    (oData),
      .oNum     (oNum),
      .oValid   (oValid),
      .oErr     (oErr),
      .oErrCode (oErrCode),
      .oErrCnt  (oErrCnt),
      .oBusy    (oBusy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          is_err;
      int          at;
      logic [31:0] data;
      logic [7:0]  num;
      logic [1:0]  code;
      logic [7:0]  cnt;
   } ev_t;

   ev_t        sb[$];
   int         nvec  = 0;
   int         nfail = 0;
   int         cyc   = 0;
   logic [7:0] exp_cnt = 8'd0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: every output event must match the head of the scoreboard.
   always @(negedge clk) begin
      ev_t e;
      if (oValid === 1'b1 || oErr === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_event", {30'd0, oValid, oErr}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("event_kind", {30'd0, oValid, oErr}, e.is_err ? 32'd1 : 32'd2);
            if (e.at >= 0) chk("event_cycle", cyc, e.at);
            if (e.is_err) begin
               chk("err_code", {30'd0, oErrCode}, {30'd0, e.code});
            end else begin
               chk("data", oData, e.data);
               chk("num", {24'd0, oNum}, {24'd0, e.num});
            end
            chk("err_cnt", {24'd0, oErrCnt}, {24'd0, e.cnt});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic irq(input logic [7:0] n);
      iRQ    = 1'b1;
      iRQnum = n;
      tick();
      iRQ    = 1'b0;
   endtask

   // Sends n bytes; one idle cycle between bytes but none after the last,
   // so an expectation can be queued right after the final byte is sampled.
   task automatic send_n(input logic [7:0] s [8], input int n);
      for (int i = 0; i < n; i++) begin
         iData  = s[i];
         iValid = 1'b1;
         tick();
         iValid = 1'b0;
         if (i != n - 1) tick();
      end
   endtask

   task automatic exp_ok(input logic [31:0] d, input logic [7:0] n);
      ev_t e;
      e.is_err = 1'b0; e.at = cyc; e.data = d; e.num = n; e.code = 2'b00; e.cnt = exp_cnt;
      sb.push_back(e);
   endtask

   task automatic exp_err(input logic [1:0] c, input int at);
      ev_t e;
      if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      e.is_err = 1'b1; e.at = at; e.data = 32'd0; e.num = 8'd0; e.code = c; e.cnt = exp_cnt;
      sb.push_back(e);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_oData"},    oData, 32'd0);
      chk({tag, "_oNum"},     {24'd0, oNum}, 32'd0);
      chk({tag, "_oValid"},   {31'd0, oValid}, 32'd0);
      chk({tag, "_oErr"},     {31'd0, oErr}, 32'd0);
      chk({tag, "_oErrCode"}, {30'd0, oErrCode}, 32'd0);
      chk({tag, "_oErrCnt"},  {24'd0, oErrCnt}, 32'd0);
      chk({tag, "_oBusy"},    {31'd0, oBusy}, 32'd0);
   endtask

   initial begin
      reset  = 1'b1;
      iRQ    = 1'b0;
      iRQnum = 8'd0;
      iData  = 8'd0;
      iValid = 1'b0;
      idle(3);
      reset = 1'b0;
      tick();
      chk_reset_outputs("reset");

      // Good frame: 05 + 11 + 22 + 33 + 44 = AF
      irq(8'h05);
      chk("busy_after_irq", {31'd0, oBusy}, 32'd1);
      send_n('{8'h7E, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAF, 8'h00}, 7);
      exp_ok(32'h11223344, 8'h05);
      idle(3);
      chk("good_idle", {31'd0, oBusy}, 32'd0);

      // Wrong echoed number
      irq(8'h05);
      send_n('{8'h7E, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2);
      exp_err(2'b10, cyc);
      idle(2);
      chk("num_err_idle", {31'd0, oBusy}, 32'd0);
      chk("num_err_data_held", oData, 32'h11223344);

      // Bad checksum byte
      irq(8'h05);
      send_n('{8'h7E, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00}, 7);
`ifdef LCC_REPLY_CSUM_EN
      exp_err(2'b11, cyc);
`else
      exp_ok(32'h11223344, 8'h05);
`endif
      idle(3);

      // No reply: timeout exactly TIMEOUT cycles after the request
      irq(8'h05);
      exp_err(2'b01, cyc + T);
      idle(T);
      chk("tmo_idle", {31'd0, oBusy}, 32'd0);
      idle(2);

      // New request mid-frame aborts the old one
      irq(8'h05);
      send_n('{8'h7E, 8'h05, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
      tick();
      irq(8'h09);
      exp_err(2'b01, cyc);
      tick();
      send_n('{8'h7E, 8'h09, 8'h01, 8'h02, 8'h03, 8'h04, 8'h13, 8'h00}, 7);
      exp_ok(32'h01020304, 8'h09);
      idle(3);
      chk("code_held", {30'd0, oErrCode}, 32'd1);

      // Request coinciding with the checksum byte wins
      irq(8'h05);
      send_n('{8'h7E, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00}, 6);
      tick();
      iData  = 8'hAF;
      iValid = 1'b1;
      irq(8'h07);
      iValid = 1'b0;
      exp_err(2'b01, cyc);
      tick();
      send_n('{8'h7E, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00}, 7);
      exp_ok(32'h00000000, 8'h07);
      idle(3);

      // A byte in the same cycle as the request is ignored
      iData  = 8'h7E;
      iValid = 1'b1;
      irq(8'h0A);
      iValid = 1'b0;
      tick();
      send_n('{8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1);
      tick();
      send_n('{8'h7E, 8'h0A, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0B, 8'h00}, 7);
      exp_ok(32'h01000000, 8'h0A);
      idle(3);

      // Saturating error counter
      for (int k = 0; k < 256; k++) begin
         irq(8'h33);
         exp_err(2'b01, cyc + T);
         idle(T);
      end
      idle(2);
      chk("errcnt_sat", {24'd0, oErrCnt}, 32'd255);
      irq(8'h33);
      exp_err(2'b01, cyc + T);
      idle(T + 2);
      chk("errcnt_hold", {24'd0, oErrCnt}, 32'd255);

      // Reset mid-frame: back to reset values, no error raised afterwards
      irq(8'h05);
      send_n('{8'h7E, 8'h05, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
      chk("sb_empty_pre_reset", sb.size(), 32'd0);
      reset = 1'b1;
      tick();
      reset   = 1'b0;
      exp_cnt = 8'd0;
      chk_reset_outputs("midreset");
      idle(T + 5);
      chk("midreset_idle", {31'd0, oBusy}, 32'd0);

      // Normal operation after reset
      irq(8'h05);
      send_n('{8'h7E, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAF, 8'h00}, 7);
      exp_ok(32'h11223344, 8'h05);
      idle(4);

      chk("sb_drained", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/lcc_reply_parser.md
LCC_REPLY_PARSER -- requirements
Module: lcc_reply_parser

Interface
- REQ-001 SHALL have parameter BYTES, default 4, meaning data bytes per reply frame (range 1..4).
- REQ-002 SHALL have parameter TIMEOUT, default 16'd8064, meaning max clk cycles between bytes (100 us at 80.64 MHz).
- REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
- REQ-004 SHALL have port reset, input, 1, meaning synchronous active-high reset.
- REQ-005 SHALL have port iRQ, input, 1, meaning a one-cycle pulse marking that a request was sent.
- REQ-006 SHALL have port iRQnum, input, 8, meaning the number of the request sent, sampled with iRQ.
- REQ-007 SHALL have port iData, input, 8, meaning a received UART byte.
- REQ-008 SHALL have port iValid, input, 1, meaning iData is valid this cycle (one-cycle pulse per byte).
- REQ-009 SHALL have port oData, output, 32, meaning the last good reply payload, right-aligned, first byte most significant.
- REQ-010 SHALL have port oNum, output, 8, meaning the request number of the last good reply.
- REQ-011 SHALL have port oValid, output, 1, meaning a one-cycle pulse when oData/oNum update.
- REQ-012 SHALL have port oErr, output, 1, meaning a one-cycle pulse on a failed frame.
- REQ-013 SHALL have port oErrCode, output, 2, meaning the cause of the last error: 01 timeout/abort, 10 number mismatch, 11 checksum.
- REQ-014 SHALL have port oErrCnt, output, 8, meaning saturating error count.
- REQ-015 SHALL have port oBusy, output, 1, meaning high in any state other than IDLE.

Function
- REQ-016 SHALL implement the states IDLE, WAIT_SYNC, NUM, DATA and CSUM.
- REQ-017 IDLE: iRQ SHALL latch iRQnum, clear the timer and go to WAIT_SYNC; bytes arriving in IDLE SHALL be ignored, including a byte in the same cycle as iRQ.
- REQ-018 WAIT_SYNC: a valid byte 8'h7E SHALL cause a move to NUM; other bytes SHALL be ignored.
- REQ-019 NUM: a valid byte equal to the latched number SHALL start the sum at that byte, clear the byte index and go to DATA; any other value SHALL raise error 10 and return to IDLE.
- REQ-020 DATA: each valid byte SHALL shift into a holding register and be added to the 8-bit sum (mod 256); after BYTES bytes the block SHALL go to CSUM.
- REQ-021 CSUM: a valid byte equal to the sum SHALL produce success, otherwise error 11; either outcome SHALL return to IDLE.
- REQ-022 On success, oData and oNum SHALL update and oValid SHALL pulse in the cycle after the checksum byte's iValid.
- REQ-023 The timer SHALL count every cycle outside IDLE and clear on each byte accepted in NUM, DATA or CSUM.
- REQ-024 When the timer reaches TIMEOUT-1, the block SHALL raise error 01 and return to IDLE.
- REQ-025 iRQ while busy SHALL raise error 01, latch the new number and restart in WAIT_SYNC with the timer cleared.
- REQ-026 If iRQ coincides with a frame-completing byte, iRQ SHALL win: the frame is discarded and the REQ-025 behaviour applies.
- REQ-027 On error, oErrCode SHALL update and oErr SHALL pulse one cycle after the causing event.
- REQ-028 oErrCnt SHALL increment with each oErr pulse and saturate at 255.
- REQ-029 oErrCode and oData SHALL hold their values between events.

Reset
- REQ-030 reset SHALL force state IDLE and clear the timer, sum and index.
- REQ-031 reset SHALL set oData=0, oNum=0, oValid=0, oErr=0, oErrCode=00, oErrCnt=0 and oBusy=0.
- REQ-032 reset mid-frame SHALL abandon the frame without raising an error.

Configuration
- REQ-033 With LCC_REPLY_CSUM_EN defined, the CSUM byte SHALL be compared as in REQ-021.
- REQ-034 Without LCC_REPLY_CSUM_EN, the CSUM byte SHALL be consumed and always treated as matching; error code 11 SHALL never occur, and the sum logic may be removed.

Verification
- REQ-035 Bench SHALL cover: iRQ with iRQnum=05, then bytes 7E 05 11 22 33 44 AF -> oValid pulse, oData=32'h11223344, oNum=05, oErrCnt=0.
- REQ-036 Bench SHALL cover: iRQnum=05, bytes 7E 06 ... -> oErr pulse after byte 06, oErrCode=10, state IDLE, oData unchanged.
- REQ-037 Bench SHALL cover: iRQnum=05, bytes 7E 05 11 22 33 44 00 -> with macro: oErrCode=11; without macro: oValid pulse and oData=32'h11223344.
- REQ-038 Bench SHALL cover: iRQ then no bytes -> oErr with oErrCode=01 exactly TIMEOUT cycles later, then oBusy=0.
- REQ-039 Bench SHALL cover: iRQ=05, bytes 7E 05 11, then iRQ=09, then frame 7E 09 01 02 03 04 13 -> one error 01, then oValid with oData=32'h01020304 and oNum=09.
- REQ-040 Bench SHALL cover: 256 consecutive timeouts -> oErrCnt=255 and holding; reset asserted mid-frame -> all outputs at reset values and no oErr pulse.
